// File: rtl/updown_mod_counter_if.sv
// rtl/updown_mod_counter_if.sv - control/status bundle for updown_mod_counter
interface updown_mod_counter_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    modport master (
        output en, up, load, load_val, clr_ovf,
        input  count, tc, ovf
    );

    modport slave (
        input  en, up, load, load_val, clr_ovf,
        output count, tc, ovf
    );
endinterface

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - parametrised up/down modulo counter with wrap or saturate
module updown_mod_counter #(
    parameter int              WIDTH    = 3,
    parameter longint unsigned MOD      = 8,
    parameter bit              SATURATE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    updown_mod_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MOD - 64'd1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             ovf_q;

    logic [WIDTH-1:0] step_count;
    logic             boundary;
    logic [WIDTH-1:0] load_fix;

    // When MOD = 2^WIDTH, MAX is all ones so the clamp never fires.
    assign load_fix = (bus.load_val > MAX) ? MAX : bus.load_val;

    // Boundary detection happens before arithmetic so nothing exceeds MAX.
    always_comb begin
        step_count = count_q;
        boundary   = 1'b0;
        if (bus.up) begin
            if (count_q == MAX) begin
                boundary   = 1'b1;
                step_count = SATURATE ? MAX : ZERO;
            end else begin
                step_count = count_q + ONE;
            end
        end else begin
            if (count_q == ZERO) begin
                boundary   = 1'b1;
                step_count = SATURATE ? ZERO : MAX;
            end else begin
                step_count = count_q - ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (bus.load) begin
            count_q <= load_fix;
            tc_q    <= 1'b0;
            if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end else if (bus.en) begin
            count_q <= step_count;
            tc_q    <= boundary;
            // A boundary event in the same cycle as clr_ovf keeps the flag set.
            if (boundary) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end else begin
            tc_q <= 1'b0;
            if (bus.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - self-checking bench for three counter configurations
module tb_updown_mod_counter;
    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] lv;
    logic       clr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // DUT0: W3 M8 wrap, DUT1: W4 M10 wrap, DUT2: W3 M8 saturate; shared stimulus.
    updown_mod_counter_if #(.WIDTH(3)) ifc0 ();
    updown_mod_counter_if #(.WIDTH(4)) ifc1 ();
    updown_mod_counter_if #(.WIDTH(3)) ifc2 ();

    assign ifc0.en = en;  assign ifc0.up = up;  assign ifc0.load = load;
    assign ifc0.clr_ovf = clr;  assign ifc0.load_val = lv[2:0];
    assign ifc1.en = en;  assign ifc1.up = up;  assign ifc1.load = load;
    assign ifc1.clr_ovf = clr;  assign ifc1.load_val = lv;
    assign ifc2.en = en;  assign ifc2.up = up;  assign ifc2.load = load;
    assign ifc2.clr_ovf = clr;  assign ifc2.load_val = lv[2:0];

    updown_mod_counter #(.WIDTH(3), .MOD(8),  .SATURATE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));
    updown_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));
    updown_mod_counter #(.WIDTH(3), .MOD(8),  .SATURATE(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(ifc2));

    int md[3] = '{8, 10, 8};
    int wd[3] = '{3, 4, 3};
    bit st[3] = '{1'b0, 1'b0, 1'b1};

    int mc[3];
    bit mtc[3];
    bit movf[3];
    int ac[3];
    bit atc[3];
    bit aovf[3];

    typedef struct {
        string      name;
        logic       rst, en, up, load;
        logic [3:0] lv;
        logic       clr;
        int         k;
        int         cnt;
        logic       tc, ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string nm, logic r, logic e, logic u, logic l,
                                logic [3:0] v, logic c, int k, int cnt, logic t, logic o);
        vec_t x;
        x.name = nm; x.rst = r; x.en = e; x.up = u; x.load = l; x.lv = v; x.clr = c;
        x.k = k; x.cnt = cnt; x.tc = t; x.ovf = o;
        vecs.push_back(x);
    endfunction

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic on integers, events when the step leaves 0..MOD-1.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int lvk;
            int raw;
            bit ev;
            lvk = int'(lv) % (1 << wd[k]);
            ev  = 1'b0;
            if (rst) begin
                mc[k] = 0; mtc[k] = 1'b0; movf[k] = 1'b0;
            end else if (load) begin
                mc[k]  = (lvk < md[k]) ? lvk : md[k] - 1;
                mtc[k] = 1'b0;
                if (clr) movf[k] = 1'b0;
            end else begin
                if (en) begin
                    raw = up ? mc[k] + 1 : mc[k] - 1;
                    ev  = (raw < 0) || (raw >= md[k]);
                    if (!ev)        mc[k] = raw;
                    else if (!st[k]) mc[k] = (raw + md[k]) % md[k];
                end
                mtc[k] = ev;
                if (ev)       movf[k] = 1'b1;
                else if (clr) movf[k] = 1'b0;
            end
        end
    endtask

    task automatic step_and_score();
        @(posedge clk);
        #1;
        model_step();
        ac[0] = int'(ifc0.count); atc[0] = ifc0.tc; aovf[0] = ifc0.ovf;
        ac[1] = int'(ifc1.count); atc[1] = ifc1.tc; aovf[1] = ifc1.ovf;
        ac[2] = int'(ifc2.count); atc[2] = ifc2.tc; aovf[2] = ifc2.ovf;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("model_count_dut%0d", k), ac[k], mc[k]);
            check($sformatf("model_tc_dut%0d", k), int'(atc[k]), int'(mtc[k]));
            check($sformatf("model_ovf_dut%0d", k), int'(aovf[k]), int'(movf[k]));
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; lv = '0; clr = 1'b0;
        foreach (mc[k]) begin mc[k] = 0; mtc[k] = 1'b0; movf[k] = 1'b0; end

        add("rst_hold0", 1, 1, 1, 1, 4'd5, 0, 0, 0, 0, 0);
        add("rst_hold1", 1, 1, 1, 1, 4'd5, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 10; i++)
            add("up_wrap", 0, 1, 1, 0, 4'd0, 0, 0, i % 8, i == 8, i >= 8);
        add("clr_m10",     0, 0, 1, 0, 4'd0,  1, 1, 0, 0, 0);
        add("load2_m10",   0, 0, 0, 1, 4'd2,  0, 1, 2, 0, 0);
        add("down_m10_a",  0, 1, 0, 0, 4'd0,  0, 1, 1, 0, 0);
        add("down_m10_b",  0, 1, 0, 0, 4'd0,  0, 1, 0, 0, 0);
        add("down_m10_c",  0, 1, 0, 0, 4'd0,  0, 1, 9, 1, 1);
        add("down_m10_d",  0, 1, 0, 0, 4'd0,  0, 1, 8, 0, 1);
        add("sat_load6",   0, 0, 1, 1, 4'd6,  0, 2, 6, 0, 1);
        add("sat_up_a",    0, 1, 1, 0, 4'd0,  0, 2, 7, 0, 1);
        add("sat_up_b",    0, 1, 1, 0, 4'd0,  0, 2, 7, 1, 1);
        add("sat_up_c",    0, 1, 1, 0, 4'd0,  0, 2, 7, 1, 1);
        add("sat_up_d",    0, 1, 1, 0, 4'd0,  0, 2, 7, 1, 1);
        add("sat_down",    0, 1, 0, 0, 4'd0,  0, 2, 6, 0, 1);
        add("load_clamp",  0, 1, 1, 1, 4'd12, 0, 1, 9, 0, 1);
        add("load_wins",   0, 1, 1, 1, 4'd3,  0, 1, 3, 0, 1);
        add("load7",       0, 0, 1, 1, 4'd7,  0, 0, 7, 0, 1);
        add("clr_alone",   0, 0, 1, 0, 4'd0,  1, 0, 7, 0, 0);
        add("set_wins",    0, 1, 1, 0, 4'd0,  1, 0, 0, 1, 1);
        add("clr_again",   0, 0, 1, 0, 4'd0,  1, 0, 0, 0, 0);
        add("load5",       0, 0, 1, 1, 4'd5,  0, 0, 5, 0, 0);
        add("mid_rst",     1, 1, 1, 0, 4'd0,  0, 0, 0, 0, 0);
        add("resume1",     0, 1, 1, 0, 4'd0,  0, 0, 1, 0, 0);
        add("resume2",     0, 1, 1, 0, 4'd0,  0, 0, 2, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; en = vecs[i].en; up = vecs[i].up;
            load = vecs[i].load; lv = vecs[i].lv; clr = vecs[i].clr;
            step_and_score();
            check({vecs[i].name, "_count"}, ac[vecs[i].k], vecs[i].cnt);
            check({vecs[i].name, "_tc"},    int'(atc[vecs[i].k]),  int'(vecs[i].tc));
            check({vecs[i].name, "_ovf"},   int'(aovf[vecs[i].k]), int'(vecs[i].ovf));
        end

        for (int n = 0; n < 400; n++) begin
            rst  = ($urandom_range(0, 40) == 0);
            load = ($urandom_range(0, 7) == 0);
            en   = ($urandom_range(0, 3) != 0);
            up   = $urandom_range(0, 1) == 1;
            clr  = ($urandom_range(0, 7) == 0);
            lv   = 4'($urandom_range(0, 15));
            step_and_score();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down modulo counter. It generalises the team's 3-bit binary counter with configurable width and modulus, direction control, enable, parallel load, and selectable wrap or saturate mode. It also reports boundary events through a terminal-count pulse and a sticky overflow flag. It serves as a reusable timing and sequencing primitive for the combinational/sequential logic blocks.

## Interface
- WIDTH, 3: count register width in bits; legal range 1..32.
- MOD, 8: modulus; count range is 0..MOD-1; legal range 2..2^WIDTH.
- SATURATE, 0: 0 wraps at the boundaries; 1 holds at the boundaries.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- en  input  1  count enable; one step per rising edge while high.
- up  input  1  direction; 1 counts up, 0 counts down.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value to load.
- clr_ovf  input  1  clears the sticky overflow flag.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, one cycle wide.
- ovf  output  1  sticky boundary-event flag, registered.

## Operation
- Priority per edge: rst, then load, then en; otherwise count holds.
- rst: count=0, tc=0, ovf=0. This takes effect on the next edge regardless of any other input, including mid-count or mid-load.
- load:
  - count = load_val when load_val < MOD; otherwise count = MOD-1 (clamped).
  - tc=0 on a load cycle; ovf is unaffected except by clr_ovf.
- en with up=1:
  - count < MOD-1: count+1.
  - count = MOD-1: boundary event; count becomes 0 (SATURATE=0) or stays MOD-1 (SATURATE=1).
- en with up=0:
  - count > 0: count-1.
  - count = 0: boundary event; count becomes MOD-1 (SATURATE=0) or stays 0 (SATURATE=1).
- Boundary event effects:
  - tc=1 for exactly that cycle; tc=0 on every non-event cycle.
  - ovf is set to 1.
  - In SATURATE=1 mode, each repeated enabled step against a boundary is a new event, so tc stays high while en is held at the boundary.
- ovf:
  - Set by a boundary event; cleared by clr_ovf.
  - Boundary event and clr_ovf in the same cycle: ovf=1 (set wins).
  - clr_ovf alone: ovf=0 next edge.
- Direction changes take effect on the very edge where up changes; no extra latency or dead cycle.
- Arithmetic: the next-count value is computed at WIDTH bits; no intermediate result exceeds MOD-1. When MOD = 2^WIDTH, wrap is natural overflow but still flags tc.

## Timing
- Single clock domain; no combinational path from any input to any output.
- Latency: inputs sampled at edge N are reflected on count/tc/ovf after edge N (one cycle).
- After rst deasserts, the first enabled edge produces count=1 (up) or count=MOD-1 (down, wrap mode).
- tc coincides with the post-event count value, e.g. count=0 on the cycle after an up-wrap from MOD-1.
- Inputs must be stable around the rising edge of clk; there is no internal synchroniser.

## Test plan
- Reset: hold rst=1 for 2 edges with en=1, load=1 -> count=0, tc=0, ovf=0 throughout.
- Up wrap (WIDTH=3, MOD=8, SATURATE=0): rst=0, en=1, up=1 for 10 edges -> count 1..7,0,1,2; tc=1 only on the cycle count=0; ovf=1 from then on.
- Down and non-power-of-two modulus (WIDTH=4, MOD=10): load 2, then up=0 for 4 edges -> count 1,0,9,8; tc=1 on the cycle count=9.
- Saturate (MOD=8, SATURATE=1): load 6, up=1 for 4 edges -> count 7,7,7,7; tc=0,1,1,1. Then up=0 for 1 edge -> count 6, tc=0.
- Load priority and clamp (MOD=10, WIDTH=4):
  - load_val=12 with en=1 -> count=9, tc=0.
  - load and en together at count=9 with up=1 -> loaded value wins, no tc.
- ovf and mid-run reset:
  - clr_ovf on the same edge as a wrap -> ovf stays 1.
  - clr_ovf alone -> ovf=0.
  - rst pulsed at count=5 while en=1 -> count=0 next edge, counting resumes from 1.
